rmw_ctrl: RTL and testbench

Read-modify-write sequencer for the 6502 core. It runs the memory-operand shift/rotate/increment/decrement instructions (ASL, LSR, ROL, ROR, INC, DEC) by reading the operand, computing on the shared `alu`, performing the 6502 dummy write and the final write, then reporting N/Z/C. It sits between the instruction decoder and both the CPU bus interface and the `alu` instance, whose inputs it owns while busy.

---
 rtl/rmw_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_rmw_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rmw_ctrl.sv
// Read-modify-write sequencer for 6502 ASL/LSR/ROL/ROR/INC/DEC memory operands.
// Define RMW_DUMMY_WRITE_EN to insert the NMOS double write of the original operand.
module rmw_ctrl #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] addr,
  input  logic          c_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    result,
  output logic          flag_n,
  output logic          flag_z,
  output logic          flag_c,
  output logic          flag_nz_we,
  output logic          flag_c_we,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ready,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [4:0]    alu_mode,
  output logic          alu_cin,
  input  logic [7:0]    alu_result,
  input  logic          alu_cout
);

  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SR  = 5'd2;

  localparam logic [2:0] OP_ASL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ROL = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_INC = 3'd4;
  localparam logic [2:0] OP_DEC = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_MODIFY, S_DUMMY_WR, S_WRITE, S_DONE
  } state_t;

  state_t          state, state_d;
  logic [2:0]      op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            c_q, c_d;
  logic [7:0]      operand_q, operand_d;
  logic            cout_q, cout_d;
  logic [7:0]      result_d;
  logic            illegal;

  logic            busy_d, done_d, err_d, mem_rd_d, mem_wr_d;
  logic            flag_n_d, flag_z_d, flag_c_d, flag_nz_we_d, flag_c_we_d;
  logic [AW-1:0]   mem_addr_d;
  logic [7:0]      mem_wdata_d, alu_a_d, alu_b_d;
  logic [4:0]      alu_mode_d;
  logic            alu_cin_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next state, datapath captures, and next values of every registered output.
  always_comb begin
    state_d   = state;
    op_d      = op_q;
    addr_d    = addr_q;
    c_d       = c_q;
    operand_d = operand_q;
    cout_d    = cout_q;
    result_d  = result;
    illegal   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (op <= OP_DEC) begin
            op_d    = op;
            addr_d  = addr;
            c_d     = c_in;
            state_d = S_READ;
          end else begin
            illegal = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (mem_ready) begin
          operand_d = mem_rdata;
          state_d   = S_MODIFY;
        end
      end
      S_MODIFY: begin
        result_d = alu_result;
        cout_d   = alu_cout;
`ifdef RMW_DUMMY_WRITE_EN
        state_d  = S_DUMMY_WR;
`else
        state_d  = S_WRITE;
`endif
      end
      S_DUMMY_WR: if (mem_ready) state_d = S_WRITE;
      S_WRITE:    if (mem_ready) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    mem_rd_d    = (state_d == S_READ);
    mem_wr_d    = (state_d == S_DUMMY_WR) || (state_d == S_WRITE);
    mem_addr_d  = (mem_rd_d || mem_wr_d) ? addr_d : '0;
    mem_wdata_d = 8'h00;
    if (state_d == S_DUMMY_WR) mem_wdata_d = operand_d;
    if (state_d == S_WRITE)    mem_wdata_d = result_d;

    alu_a_d    = 8'h00;
    alu_b_d    = 8'h00;
    alu_mode_d = 5'd0;
    alu_cin_d  = 1'b0;
    if (state_d == S_MODIFY) begin
      alu_a_d = operand_d;
      case (op_d)
        OP_ASL: begin alu_mode_d = ALU_ADD; alu_b_d = operand_d; end
        OP_ROL: begin alu_mode_d = ALU_ADD; alu_b_d = operand_d; alu_cin_d = c_d; end
        OP_LSR: alu_mode_d = ALU_SR;
        OP_ROR: begin alu_mode_d = ALU_SR; alu_cin_d = c_d; end
        OP_INC: begin alu_mode_d = ALU_ADD; alu_cin_d = 1'b1; end
        OP_DEC: begin alu_mode_d = ALU_ADD; alu_b_d = 8'hFF; end
        default: alu_a_d = 8'h00;
      endcase
    end

    done_d       = (state_d == S_DONE);
    err_d        = illegal;
    flag_nz_we_d = done_d && !illegal;
    flag_c_we_d  = flag_nz_we_d && (op_d <= OP_ROR);

    // Flags are refreshed only when a legal op completes and held otherwise.
    flag_n_d = flag_n;
    flag_z_d = flag_z;
    flag_c_d = flag_c;
    if (state == S_WRITE && state_d == S_DONE) begin
      flag_n_d = result[7];
      flag_z_d = (result == 8'h00);
      flag_c_d = cout_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= 3'd0;
      addr_q     <= '0;
      c_q        <= 1'b0;
      operand_q  <= 8'h00;
      cout_q     <= 1'b0;
      result     <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_nz_we <= 1'b0;
      flag_c_we  <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= 8'h00;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_mode   <= 5'd0;
      alu_cin    <= 1'b0;
    end else begin
      op_q       <= op_d;
      addr_q     <= addr_d;
      c_q        <= c_d;
      operand_q  <= operand_d;
      cout_q     <= cout_d;
      result     <= result_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      flag_n     <= flag_n_d;
      flag_z     <= flag_z_d;
      flag_c     <= flag_c_d;
      flag_nz_we <= flag_nz_we_d;
      flag_c_we  <= flag_c_we_d;
      mem_addr   <= mem_addr_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
      mem_wdata  <= mem_wdata_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_mode   <= alu_mode_d;
      alu_cin    <= alu_cin_d;
    end
  end

endmodule

// File: tb/tb_rmw_ctrl.sv
// Self-checking bench for rmw_ctrl: table of RMW operations plus reset-abort and illegal-op sequences.
module tb_rmw_ctrl;

  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SR  = 5'd2;
`ifdef RMW_DUMMY_WRITE_EN
  localparam int LAT = 5;
  localparam int NW  = 2;
`else
  localparam int LAT = 4;
  localparam int NW  = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op_i;
  logic [15:0] addr_i;
  logic        c_in_i;
  logic        busy, done, err;
  logic [7:0]  result;
  logic        flag_n, flag_z, flag_c, flag_nz_we, flag_c_we;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  rdata_i;
  logic        mem_ready;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [4:0]  alu_mode;
  logic        alu_cin, alu_cout;

  int checks = 0;
  int errors = 0;
  int stall_req = 0;
  int stall_cnt = 0;
  int rd_cnt = 0;
  logic [7:0]  wq[$];
  logic [15:0] aq[$];

  always #5 clk = ~clk;

  rmw_ctrl #(.AW(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op_i), .addr(addr_i), .c_in(c_in_i),
    .busy(busy), .done(done), .err(err), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
    .flag_nz_we(flag_nz_we), .flag_c_we(flag_c_we),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(rdata_i), .mem_ready(mem_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  // Reference ALU: 8-bit add with carry, and shift-right with carry in at bit 7.
  always_comb begin
    alu_result = 8'h00;
    alu_cout   = 1'b0;
    case (alu_mode)
      ALU_ADD: {alu_cout, alu_result} = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
      ALU_SR:  begin alu_result = {alu_cin, alu_a[7:1]}; alu_cout = alu_a[0]; end
      default: ;
    endcase
  end

  // Memory: reads stall for stall_req cycles, writes are always ready and logged.
  assign mem_ready = !(mem_rd && (stall_cnt < stall_req));

  always @(posedge clk) begin
    if (mem_rd && !mem_ready) stall_cnt <= stall_cnt + 1;
    else if (!mem_rd)         stall_cnt <= 0;
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (mem_wr && mem_ready) begin
      wq.push_back(mem_wdata);
      aq.push_back(mem_addr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        c;
    logic [15:0] addr;
    logic [7:0]  rdata;
    int          stall;
    bit          poke;
    logic [7:0]  res;
    logic        n;
    logic        z;
    logic        cf;
    logic        cwe;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v);
    int  cyc;
    bit  got;
    @(negedge clk);
    wq.delete();
    aq.delete();
    rd_cnt    = 0;
    stall_req = v.stall;
    op_i      = v.op;
    c_in_i    = v.c;
    addr_i    = v.addr;
    rdata_i   = v.rdata;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    got   = 1'b0;
    while (cyc < 40) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (cyc <= v.stall + 1) chk("read_hold", 32'({mem_rd, mem_addr}), 32'({1'b1, v.addr}));
      if (v.poke && cyc == 2) begin
        start = 1'b1; op_i = 3'd5; addr_i = 16'hFFFF; c_in_i = ~v.c;
      end
      if (v.poke && cyc == 3) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc), 32'(LAT + v.stall));
    chk("err", 32'(err), 32'd0);
    chk("result", 32'(result), 32'(v.res));
    chk("flag_n", 32'(flag_n), 32'(v.n));
    chk("flag_z", 32'(flag_z), 32'(v.z));
    chk("flag_nz_we", 32'(flag_nz_we), 32'd1);
    chk("flag_c_we", 32'(flag_c_we), 32'(v.cwe));
    if (v.cwe) chk("flag_c", 32'(flag_c), 32'(v.cf));
    chk("alu_idle", 32'({alu_mode, alu_a, alu_b, alu_cin}), 32'd0);
    chk("read_count", 32'(rd_cnt), 32'(v.stall + 1));
    chk("write_count", 32'(wq.size()), 32'(NW));
    if (wq.size() > 0) chk("final_wdata", 32'(wq[wq.size()-1]), 32'(v.res));
`ifdef RMW_DUMMY_WRITE_EN
    if (wq.size() == 2) chk("dummy_wdata", 32'(wq[0]), 32'(v.rdata));
`endif
    foreach (aq[i]) chk("write_addr", 32'(aq[i]), 32'(v.addr));
    @(negedge clk);
    chk("idle_after", 32'({busy, done, mem_rd, mem_wr}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int  seen;
    //          op    c     addr      rd     st poke res    n     z     cf    cwe
    vecs[0] = '{3'd0, 1'b1, 16'h0200, 8'h80, 0, 0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{3'd3, 1'b1, 16'h0010, 8'h01, 0, 0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{3'd5, 1'b0, 16'h0300, 8'h00, 0, 0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{3'd4, 1'b0, 16'h0301, 8'hFF, 0, 0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{3'd4, 1'b0, 16'h1234, 8'h41, 3, 0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{3'd1, 1'b1, 16'h00FF, 8'h81, 0, 0, 8'h40, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{3'd2, 1'b1, 16'hABCD, 8'h40, 0, 1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{3'd2, 1'b0, 16'h0001, 8'h80, 0, 0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{3'd0, 1'b0, 16'h0400, 8'h01, 0, 0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0;
    start   = 1'b0;
    op_i    = 3'd0;
    addr_i  = 16'h0000;
    c_in_i  = 1'b0;
    rdata_i = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({busy, done, err, mem_rd, mem_wr, flag_nz_we, flag_c_we}), 32'd0);
    chk("reset_data", 32'({result, mem_wdata, alu_mode}), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Abort during the final write: outputs must drop asynchronously and no done appear.
    @(negedge clk);
    wq.delete();
    stall_req = 0;
    op_i = 3'd0; addr_i = 16'h0500; c_in_i = 1'b0; rdata_i = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT - 2) @(negedge clk);
    chk("pre_abort_wr", 32'({mem_wr, busy}), 32'b11);
    #2 reset_n = 1'b0;
    #1 chk("abort_async", 32'({mem_wr, busy, mem_rd, done}), 32'd0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    reset_n = 1'b1;
    run_vec(vecs[8]);

    // Illegal ops complete in one cycle with no bus traffic or flag updates.
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      rd_cnt = 0;
      wq.delete();
      op_i  = 3'(k);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("illegal_done_err", 32'({done, err, busy}), 32'b111);
      chk("illegal_quiet", 32'({mem_rd, mem_wr, flag_nz_we, flag_c_we}), 32'd0);
      @(negedge clk);
      chk("illegal_after", 32'({done, err, busy}), 32'd0);
      chk("illegal_no_bus", 32'(rd_cnt + int'(wq.size())), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
